sha256_block_engine: RTL and testbench
======================================

SHA256_BLOCK_ENGINE -- requirements
Module: sha256_block_engine

Interface
REQ-001 The block SHALL have parameter ROUNDS_PER_CYCLE, default 1; the SHA-256 rounds executed per COMPRESS cycle; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 The block SHALL have parameter BLK_CNT_W, default 8; the width of block_count.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a new message; sampled only in IDLE.
REQ-006 The block SHALL have port word_data, input, 32 bits: big-endian message word.
REQ-007 The block SHALL have port word_valid, input, 1 bit: word_data (and word_last) valid.
REQ-008 The block SHALL have port word_last, input, 1 bit: current block is the final block; sampled with the 16th word of each block.
REQ-009 The block SHALL have port word_ready, output, 1 bit: the engine accepts a word.
REQ-010 The block SHALL have port busy, output, 1 bit: a message is in progress.
REQ-011 The block SHALL have port block_count, output, BLK_CNT_W bits: number of blocks completed in the current message.
REQ-012 The block SHALL have port hash_out, output, 256 bits: the digest, H0 in [255:224] through H7 in [31:0].
REQ-013 The block SHALL have port hash_valid, output, 1 bit: hash_out is valid.
REQ-014 The block SHALL have port hash_ack, input, 1 bit: consumer accepted the digest.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, COMPRESS, UPDATE and DONE.
REQ-016 In IDLE, start=1 SHALL load H0..H7 with the FIPS 180-4 initial values, clear block_count, and move to LOAD.
REQ-017 In LOAD, word_ready SHALL be 1, and a word SHALL be accepted on each cycle where word_valid && word_ready.
REQ-018 A 4-bit word counter SHALL count accepted words; gaps in word_valid SHALL stall it without any loss of state.
REQ-019 On acceptance of the 16th word, the block SHALL latch word_last, set a..h = H0..H7 and round=0, and move to COMPRESS.
REQ-020 The message schedule SHALL be held in a 16-word sliding window.
REQ-021 For t>=16, W[t] SHALL equal s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], computed on the fly.
REQ-022 The window SHALL shift by ROUNDS_PER_CYCLE words per cycle, and no 64-entry RAM SHALL be used.
REQ-023 COMPRESS SHALL run for exactly 64/ROUNDS_PER_CYCLE cycles, chaining ROUNDS_PER_CYCLE standard rounds combinationally per cycle, with K[t] from the constant ROM.
REQ-024 After the final compress cycle, the FSM SHALL go to UPDATE.
REQ-025 UPDATE SHALL last 1 cycle and perform Hi <= Hi + working variable (mod 2^32).
REQ-026 UPDATE SHALL increment block_count, saturating at all-ones.
REQ-027 From UPDATE, the FSM SHALL go to DONE if the latched word_last=1, else to LOAD.
REQ-028 On entry to DONE, the block SHALL register hash_out = {H0..H7} and set hash_valid=1.
REQ-029 hash_out and hash_valid SHALL hold stable until hash_ack.
REQ-030 hash_ack=1 in DONE SHALL clear hash_valid and move to IDLE; hash_out SHALL retain its value.
REQ-031 hash_ack outside DONE SHALL be ignored.
REQ-032 busy SHALL be 1 in LOAD, COMPRESS and UPDATE, and 0 in IDLE and DONE.
REQ-033 word_ready SHALL be 0 in every state except LOAD.
REQ-034 start outside IDLE SHALL be ignored, including start coincident with hash_ack in DONE; a new message requires start in IDLE.
REQ-035 Latency: hash_valid SHALL rise 64/ROUNDS_PER_CYCLE+1 cycles after the edge that accepts the 16th word of the last block (65 cycles at R=1, 17 at R=4).
REQ-036 The minimum per-block period SHALL be 16 + 64/ROUNDS_PER_CYCLE + 1 cycles.
REQ-037 All additions SHALL be 32-bit modulo 2^32, with carries discarded.

Reset
REQ-038 rst_n=0 SHALL asynchronously force state IDLE, with busy=0, word_ready=0, hash_valid=0, hash_out=0, block_count=0, the word counter and round counter =0, and H0..H7 = the initial values.
REQ-039 Reset asserted mid-LOAD or mid-COMPRESS SHALL abandon the message, and after release no partial result SHALL be output.
REQ-040 The window and working registers need no reset.

Verification
REQ-041 Bench: "abc" single padded block, word_last on word 16, R=1 -> hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; hash_valid 65 cycles after the 16th accept; block_count=1.
REQ-042 Bench: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded, word_last only on block 2 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; block_count=2.
REQ-043 Bench: repeat REQ-041 with random word_valid gaps (0-5 cycles) -> identical digest; no word dropped or duplicated; word_ready=0 outside LOAD.
REQ-044 Bench: ROUNDS_PER_CYCLE=2 and 4 builds with the REQ-042 message -> identical digest; COMPRESS lasts 32 and 16 cycles respectively.
REQ-045 Bench: hold hash_ack=0 for 20 cycles in DONE -> hash_valid and hash_out stable; start pulsed in DONE is ignored; hash_ack -> IDLE next cycle, and a new start then yields the correct fresh "abc" digest.
REQ-046 Bench: assert rst_n=0 at round 30 of a block -> all outputs at reset values immediately; after release, "abc" produces the REQ-041 digest.

Source files
------------

// File: rtl/sha256_block_engine_if.sv
// Handshake and result bundle for sha256_block_engine.
// The engine connects through the slave modport; the producer/consumer uses master.
interface sha256_block_engine_if #(
    parameter int BLK_CNT_W = 8
) ();
    logic                 start;
    logic [31:0]          word_data;
    logic                 word_valid;
    logic                 word_last;
    logic                 word_ready;
    logic                 busy;
    logic [BLK_CNT_W-1:0] block_count;
    logic [255:0]         hash_out;
    logic                 hash_valid;
    logic                 hash_ack;

    modport master (
        output start, word_data, word_valid, word_last, hash_ack,
        input  word_ready, busy, block_count, hash_out, hash_valid
    );

    modport slave (
        input  start, word_data, word_valid, word_last, hash_ack,
        output word_ready, busy, block_count, hash_out, hash_valid
    );
endinterface

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: takes pre-padded 512-bit blocks as 16 big-endian words,
// runs 1/2/4 rounds per cycle over a 16-word sliding schedule window.
module sha256_block_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int BLK_CNT_W        = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    sha256_block_engine_if.slave bus
);
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [5:0]   LAST_ROUND = 6'(64 / ROUNDS_PER_CYCLE - 1);
    localparam logic [255:0] H_INIT = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0]  K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {IDLE, LOAD, COMPRESS, UPDATE, DONE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t               state, state_nxt;
    logic [31:0]          h    [8];
    logic [31:0]          wv   [8];
    logic [31:0]          v    [8];
    logic [31:0]          win  [16];
    logic [31:0]          ext  [16+ROUNDS_PER_CYCLE];
    logic [3:0]           word_cnt;
    logic [5:0]           round_cnt;
    logic [5:0]           kidx;
    logic [31:0]          t1, t2;
    logic [BLK_CNT_W-1:0] blk_cnt;
    logic [255:0]         hash_out_r;
    logic                 hash_valid_r;
    logic                 last_blk;
    logic                 accept;

    // ext[16..] extends the window by the words needed after this cycle's shift
    always_comb begin
        kidx = '0;
        t1   = '0;
        t2   = '0;
        for (int unsigned i = 0; i < 16; i++) ext[i] = win[i];
        for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++)
            ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
        for (int unsigned i = 0; i < 8; i++) v[i] = wv[i];
        for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            kidx = 6'(int'(round_cnt) * ROUNDS_PER_CYCLE + int'(j));
            t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[kidx] + ext[j];
            t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6];
            v[6] = v[5];
            v[5] = v[4];
            v[4] = v[3] + t1;
            v[3] = v[2];
            v[2] = v[1];
            v[1] = v[0];
            v[0] = t1 + t2;
        end
    end

    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        bus.word_ready  = 1'b0;
        bus.busy        = 1'b0;
        bus.block_count = blk_cnt;
        bus.hash_out    = hash_out_r;
        bus.hash_valid  = hash_valid_r;
        case (state)
            IDLE:     if (bus.start) state_nxt = LOAD;
            LOAD: begin
                bus.word_ready = 1'b1;
                bus.busy       = 1'b1;
                accept         = bus.word_valid;
                if (accept && word_cnt == 4'd15) state_nxt = COMPRESS;
            end
            COMPRESS: begin
                bus.busy = 1'b1;
                if (round_cnt == LAST_ROUND) state_nxt = UPDATE;
            end
            UPDATE: begin
                bus.busy  = 1'b1;
                state_nxt = last_blk ? DONE : LOAD;
            end
            DONE:     if (bus.hash_ack) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            word_cnt     <= '0;
            round_cnt    <= '0;
            blk_cnt      <= '0;
            hash_out_r   <= '0;
            hash_valid_r <= 1'b0;
            last_blk     <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) h[i] <= H_INIT[255-32*i -: 32];
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.start) begin
                    blk_cnt  <= '0;
                    word_cnt <= '0;
                    for (int unsigned i = 0; i < 8; i++) h[i] <= H_INIT[255-32*i -: 32];
                end
                LOAD: if (accept) begin
                    word_cnt <= word_cnt + 4'd1;
                    if (word_cnt == 4'd15) begin
                        last_blk  <= bus.word_last;
                        round_cnt <= '0;
                    end
                end
                COMPRESS: round_cnt <= (round_cnt == LAST_ROUND) ? '0 : round_cnt + 6'd1;
                UPDATE: begin
                    if (blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
                    for (int unsigned i = 0; i < 8; i++) begin
                        h[i] <= h[i] + wv[i];
                        if (last_blk) hash_out_r[255-32*i -: 32] <= h[i] + wv[i];
                    end
                    if (last_blk) hash_valid_r <= 1'b1;
                end
                DONE: if (bus.hash_ack) hash_valid_r <= 1'b0;
                default: ;
            endcase
        end
    end

    // Schedule window and working variables carry no reset: always reloaded before use
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= bus.word_data;
            if (word_cnt == 4'd15)
                for (int unsigned i = 0; i < 8; i++) wv[i] <= h[i];
        end else if (state == COMPRESS) begin
            for (int unsigned i = 0; i < 16; i++) win[i] <= ext[i+ROUNDS_PER_CYCLE];
            for (int unsigned i = 0; i < 8; i++) wv[i] <= v[i];
        end
    end
endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench for sha256_block_engine: FIPS "abc" and two-block vectors at R=1/2/4,
// valid gaps, held ack, and mid-compress reset.
module tb_sha256_block_engine;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIGEST = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic [31:0] abc_words [16] = '{
        32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018
    };
    logic [31:0] two_words [32] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  word_data = '0;
    logic         word_valid = 1'b0;
    logic         word_last = 1'b0;
    logic         hash_ack = 1'b0;
    logic         word_ready, busy, hash_valid;
    logic [7:0]   block_count;
    logic [255:0] hash_out;
    int           sel = 1;
    int           passed = 0;
    int           total = 0;
    int           lat;
    bit           tmo, ready_bad;

    always #5 clk = ~clk;

    sha256_block_engine_if #(.BLK_CNT_W(8)) bus1 ();
    sha256_block_engine_if #(.BLK_CNT_W(8)) bus2 ();
    sha256_block_engine_if #(.BLK_CNT_W(8)) bus4 ();

    sha256_block_engine #(.ROUNDS_PER_CYCLE(1), .BLK_CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    sha256_block_engine #(.ROUNDS_PER_CYCLE(2), .BLK_CNT_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    sha256_block_engine #(.ROUNDS_PER_CYCLE(4), .BLK_CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    assign bus1.start      = (sel == 1) ? start : 1'b0;
    assign bus1.word_data  = word_data;
    assign bus1.word_valid = (sel == 1) ? word_valid : 1'b0;
    assign bus1.word_last  = word_last;
    assign bus1.hash_ack   = (sel == 1) ? hash_ack : 1'b0;
    assign bus2.start      = (sel == 2) ? start : 1'b0;
    assign bus2.word_data  = word_data;
    assign bus2.word_valid = (sel == 2) ? word_valid : 1'b0;
    assign bus2.word_last  = word_last;
    assign bus2.hash_ack   = (sel == 2) ? hash_ack : 1'b0;
    assign bus4.start      = (sel == 4) ? start : 1'b0;
    assign bus4.word_data  = word_data;
    assign bus4.word_valid = (sel == 4) ? word_valid : 1'b0;
    assign bus4.word_last  = word_last;
    assign bus4.hash_ack   = (sel == 4) ? hash_ack : 1'b0;

    assign word_ready  = (sel == 2) ? bus2.word_ready  : (sel == 4) ? bus4.word_ready  : bus1.word_ready;
    assign busy        = (sel == 2) ? bus2.busy        : (sel == 4) ? bus4.busy        : bus1.busy;
    assign hash_valid  = (sel == 2) ? bus2.hash_valid  : (sel == 4) ? bus4.hash_valid  : bus1.hash_valid;
    assign block_count = (sel == 2) ? bus2.block_count : (sel == 4) ? bus4.block_count : bus1.block_count;
    assign hash_out    = (sel == 2) ? bus2.hash_out    : (sel == 4) ? bus4.hash_out    : bus1.hash_out;

    // All stimulus tasks are entered and left at posedge+1
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        hash_ack = 1'b1;
        @(posedge clk); #1;
        hash_ack = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input int unsigned gap);
        int n;
        word_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        word_data  = d;
        word_last  = last;
        word_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!word_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!word_ready) tmo = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic run_msg(input bit two, input bit gaps);
        int nblk;
        tmo       = 1'b0;
        ready_bad = 1'b0;
        nblk      = two ? 2 : 1;
        pulse_start();
        for (int b = 0; b < nblk; b++)
            for (int i = 0; i < 16; i++)
                send_word(two ? two_words[b*16+i] : abc_words[i], (b == nblk-1) && (i == 15),
                          gaps ? $urandom_range(5, 0) : 0);
        lat = 0;
        while (!hash_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (word_ready) ready_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        sel   = 1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (word_ready !== 1'b0) $display("FAIL reset_word_ready: got %b expected 0", word_ready); else passed++;
        total++; if (hash_valid !== 1'b0) $display("FAIL reset_hash_valid: got %b expected 0", hash_valid); else passed++;
        total++; if (hash_out !== '0) $display("FAIL reset_hash_out: got %h expected 0", hash_out); else passed++;
        total++; if (block_count !== 8'd0) $display("FAIL reset_block_count: got %0d expected 0", block_count); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        sel = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL abc_busy_in_load: got %b expected 1", busy); else passed++;
        total++; if (word_ready !== 1'b1) $display("FAIL abc_ready_in_load: got %b expected 1", word_ready); else passed++;
        tmo = 1'b0;
        ready_bad = 1'b0;
        for (int i = 0; i < 16; i++) send_word(abc_words[i], i == 15, 0);
        lat = 0;
        while (!hash_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (word_ready) ready_bad = 1'b1;
        end
        total++; if (tmo !== 1'b0) $display("FAIL abc_handshake: timeout waiting for word_ready"); else passed++;
        total++; if (lat !== 65) $display("FAIL abc_latency: got %0d expected 65", lat); else passed++;
        total++; if (hash_out !== ABC_DIGEST) $display("FAIL abc_digest: got %h expected %h", hash_out, ABC_DIGEST); else passed++;
        total++; if (block_count !== 8'd1) $display("FAIL abc_block_count: got %0d expected 1", block_count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abc_busy_in_done: got %b expected 0", busy); else passed++;
        total++; if (ready_bad !== 1'b0) $display("FAIL abc_ready_outside_load: got 1 expected 0"); else passed++;
        pulse_ack();
        total++; if (hash_valid !== 1'b0) $display("FAIL abc_ack_clears_valid: got %b expected 0", hash_valid); else passed++;
        total++; if (hash_out !== ABC_DIGEST) $display("FAIL abc_hash_retained: got %h expected %h", hash_out, ABC_DIGEST); else passed++;
    endtask

    task automatic test_two_block(input int r);
        int exp_lat;
        sel = r;
        exp_lat = 64 / r + 1;
        run_msg(1'b1, 1'b0);
        total++; if (tmo !== 1'b0) $display("FAIL two_r%0d_handshake: timeout waiting for word_ready", r); else passed++;
        total++; if (lat !== exp_lat) $display("FAIL two_r%0d_latency: got %0d expected %0d", r, lat, exp_lat); else passed++;
        total++; if (hash_out !== TWO_DIGEST) $display("FAIL two_r%0d_digest: got %h expected %h", r, hash_out, TWO_DIGEST); else passed++;
        total++; if (block_count !== 8'd2) $display("FAIL two_r%0d_block_count: got %0d expected 2", r, block_count); else passed++;
        pulse_ack();
        sel = 1;
    endtask

    task automatic test_gaps();
        sel = 1;
        run_msg(1'b0, 1'b1);
        total++; if (tmo !== 1'b0) $display("FAIL gaps_handshake: timeout waiting for word_ready"); else passed++;
        total++; if (hash_out !== ABC_DIGEST) $display("FAIL gaps_digest: got %h expected %h", hash_out, ABC_DIGEST); else passed++;
        total++; if (lat !== 65) $display("FAIL gaps_latency: got %0d expected 65", lat); else passed++;
        total++; if (ready_bad !== 1'b0) $display("FAIL gaps_ready_outside_load: got 1 expected 0"); else passed++;
        pulse_ack();
    endtask

    task automatic test_hold_ack();
        bit unstable;
        sel = 1;
        run_msg(1'b0, 1'b0);
        unstable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            @(posedge clk); #1;
            start = 1'b0;
            if (hash_valid !== 1'b1 || hash_out !== ABC_DIGEST || busy !== 1'b0 || word_ready !== 1'b0)
                unstable = 1'b1;
        end
        total++; if (unstable !== 1'b0) $display("FAIL hold_done_stable: got unstable expected stable"); else passed++;
        start    = 1'b1;
        hash_ack = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        hash_ack = 1'b0;
        total++; if (hash_valid !== 1'b0) $display("FAIL hold_ack_valid: got %b expected 0", hash_valid); else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL hold_start_with_ack_ignored: busy %b expected 0", busy); else passed++;
        run_msg(1'b0, 1'b0);
        total++; if (hash_out !== ABC_DIGEST) $display("FAIL hold_fresh_digest: got %h expected %h", hash_out, ABC_DIGEST); else passed++;
        total++; if (block_count !== 8'd1) $display("FAIL hold_fresh_block_count: got %0d expected 1", block_count); else passed++;
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        bit spurious;
        sel = 1;
        tmo = 1'b0;
        pulse_start();
        for (int i = 0; i < 32; i++) send_word(two_words[i], 1'b0, 0);
        repeat (30) @(posedge clk);
        #1;
        total++; if (block_count !== 8'd1) $display("FAIL midrst_pre_block_count: got %0d expected 1", block_count); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else passed++;
        total++; if (hash_out !== '0) $display("FAIL midrst_hash_out: got %h expected 0", hash_out); else passed++;
        total++; if (block_count !== 8'd0) $display("FAIL midrst_block_count: got %0d expected 0", block_count); else passed++;
        total++; if (word_ready !== 1'b0 || hash_valid !== 1'b0) $display("FAIL midrst_ready_valid: got %b%b expected 00", word_ready, hash_valid); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (hash_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        total++; if (spurious !== 1'b0) $display("FAIL midrst_no_partial_result: got activity expected idle"); else passed++;
        run_msg(1'b0, 1'b0);
        total++; if (hash_out !== ABC_DIGEST) $display("FAIL midrst_digest: got %h expected %h", hash_out, ABC_DIGEST); else passed++;
        total++; if (lat !== 65) $display("FAIL midrst_latency: got %0d expected 65", lat); else passed++;
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block(1);
        test_gaps();
        test_hold_ack();
        test_reset_mid();
        test_two_block(2);
        test_two_block(4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
